// File: rtl/loop_flow_mul_unit.sv
// rtl/loop_flow_mul_unit.sv - loop flow control plus pipelined signed multiplier for the mat-vec row loop
module loop_flow_mul_unit #(
  parameter int DIN0_WIDTH = 29,
  parameter int DIN1_WIDTH = 64,
  parameter int DOUT_WIDTH = 92,
  parameter int NUM_STAGE  = 5
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_start_int,
  output logic                  ap_loop_init,
  input  logic                  ap_ready_int,
  input  logic                  ap_loop_exit_ready,
  input  logic                  ap_loop_exit_done,
  output logic                  ap_continue_int,
  input  logic                  ap_done_int,
  input  logic                  mul_ce,
  input  logic [DIN0_WIDTH-1:0] mul_din0,
  input  logic [DIN1_WIDTH-1:0] mul_din1,
  output logic [DOUT_WIDTH-1:0] mul_dout
);

  // Operand registers take one of the HLS stages; the rest hold the product.
  localparam int PIPE_DEPTH = NUM_STAGE - 2;

  logic init_flag;
  logic done_cache;
  logic unused_done_int;

  assign unused_done_int = ap_done_int;

  assign ap_start_int    = ap_start;
  assign ap_ready        = ap_loop_exit_ready;
  assign ap_continue_int = 1'b1;
  assign ap_loop_init    = init_flag & ap_start;
  assign ap_done         = ap_loop_exit_done | done_cache;

  // Exit re-arms init before ready_int can clear it, so the next invocation restarts at iteration 0.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      init_flag <= 1'b1;
    end else if (ap_loop_exit_ready) begin
      init_flag <= 1'b1;
    end else if (ap_ready_int) begin
      init_flag <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      done_cache <= 1'b0;
    end else if (ap_loop_exit_done && !ap_continue_int) begin
      done_cache <= 1'b1;
    end else if (ap_continue_int) begin
      done_cache <= 1'b0;
    end
  end

  logic [DIN0_WIDTH-1:0]        a_reg;
  logic [DIN1_WIDTH-1:0]        b_reg;
  logic signed [DOUT_WIDTH-1:0] a_ext;
  logic signed [DOUT_WIDTH-1:0] b_ext;
  logic signed [DOUT_WIDTH-1:0] product;
  logic [DOUT_WIDTH-1:0]        p_reg [PIPE_DEPTH];

  // Sign-extend to the full product width so the multiply wraps at DOUT_WIDTH bits.
  assign a_ext   = {{(DOUT_WIDTH - DIN0_WIDTH){a_reg[DIN0_WIDTH-1]}}, a_reg};
  assign b_ext   = {{(DOUT_WIDTH - DIN1_WIDTH){b_reg[DIN1_WIDTH-1]}}, b_reg};
  assign product = a_ext * b_ext;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        p_reg[i] <= '0;
      end
    end else if (mul_ce) begin
      a_reg    <= mul_din0;
      b_reg    <= mul_din1;
      p_reg[0] <= product;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        p_reg[i] <= p_reg[i-1];
      end
    end
  end

  assign mul_dout = p_reg[PIPE_DEPTH-1];

endmodule

// File: tb/tb_loop_flow_mul_unit.sv
// tb/tb_loop_flow_mul_unit.sv - directed self-checking bench for loop_flow_mul_unit
module tb_loop_flow_mul_unit;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_start_int;
  logic        ap_loop_init;
  logic        ap_ready_int;
  logic        ap_loop_exit_ready;
  logic        ap_loop_exit_done;
  logic        ap_continue_int;
  logic        ap_done_int;
  logic        mul_ce;
  logic [28:0] mul_din0;
  logic [63:0] mul_din1;
  logic [91:0] mul_dout;

  int checks = 0;
  int failures = 0;

  localparam int NVEC = 8;
  logic [28:0] va [NVEC];
  logic [63:0] vb [NVEC];
  logic [91:0] ve [NVEC];

  always #5 ap_clk = ~ap_clk;

  loop_flow_mul_unit dut (
    .ap_clk             (ap_clk),
    .ap_rst_n           (ap_rst_n),
    .ap_start           (ap_start),
    .ap_ready           (ap_ready),
    .ap_done            (ap_done),
    .ap_start_int       (ap_start_int),
    .ap_loop_init       (ap_loop_init),
    .ap_ready_int       (ap_ready_int),
    .ap_loop_exit_ready (ap_loop_exit_ready),
    .ap_loop_exit_done  (ap_loop_exit_done),
    .ap_continue_int    (ap_continue_int),
    .ap_done_int        (ap_done_int),
    .mul_ce             (mul_ce),
    .mul_din0           (mul_din0),
    .mul_din1           (mul_din1),
    .mul_dout           (mul_dout)
  );

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0;
    ap_start = 1'b1;
    ap_ready_int = 1'b0;
    ap_loop_exit_ready = 1'b1;
    ap_loop_exit_done = 1'b1;
    ap_done_int = 1'b0;
    mul_ce = 1'b1;
    mul_din0 = 29'd5;
    mul_din1 = 64'd7;
    tick; tick; tick; tick;
    settle;
    checks++;
    if (mul_dout !== 92'd0) begin
      failures++;
      $display("FAIL reset_dout actual=%0h required=0", mul_dout);
    end
    checks++;
    if (ap_done !== 1'b1 || ap_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_done_ready actual=%b%b required=11", ap_done, ap_ready);
    end
    ap_loop_exit_ready = 1'b0;
    ap_loop_exit_done = 1'b0;
    settle;
    checks++;
    if (ap_done !== 1'b0 || ap_ready !== 1'b0 || ap_loop_init !== 1'b1 ||
        ap_start_int !== 1'b1 || ap_continue_int !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake actual done=%b ready=%b init=%b start_int=%b cont=%b required 0 0 1 1 1",
               ap_done, ap_ready, ap_loop_init, ap_start_int, ap_continue_int);
    end
    ap_start = 1'b0;
    ap_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_loop_init;
    ap_start = 1'b1;
    ap_ready_int = 1'b1;
    settle;
    checks++;
    if (ap_loop_init !== 1'b1) begin
      failures++;
      $display("FAIL init_first actual=%b required=1", ap_loop_init);
    end
    tick;
    ap_ready_int = 1'b0;
    settle;
    checks++;
    if (ap_loop_init !== 1'b0) begin
      failures++;
      $display("FAIL init_cleared actual=%b required=0", ap_loop_init);
    end
    ap_start = 1'b0;
    ap_loop_exit_ready = 1'b1;
    settle;
    checks++;
    if (ap_ready !== 1'b1 || ap_loop_init !== 1'b0 || ap_start_int !== 1'b0) begin
      failures++;
      $display("FAIL exit_ready_pulse actual ready=%b init=%b start_int=%b required 1 0 0",
               ap_ready, ap_loop_init, ap_start_int);
    end
    tick;
    ap_loop_exit_ready = 1'b0;
    settle;
    checks++;
    if (ap_loop_init !== 1'b0 || ap_ready !== 1'b0) begin
      failures++;
      $display("FAIL init_gated_by_start actual init=%b ready=%b required 0 0", ap_loop_init, ap_ready);
    end
    ap_start = 1'b1;
    settle;
    checks++;
    if (ap_loop_init !== 1'b1) begin
      failures++;
      $display("FAIL init_rearmed actual=%b required=1", ap_loop_init);
    end
    ap_ready_int = 1'b1;
    ap_loop_exit_ready = 1'b1;
    tick;
    ap_loop_exit_ready = 1'b0;
    settle;
    checks++;
    if (ap_loop_init !== 1'b1) begin
      failures++;
      $display("FAIL exit_beats_ready_int actual=%b required=1", ap_loop_init);
    end
    tick;
    ap_ready_int = 1'b0;
    settle;
    checks++;
    if (ap_loop_init !== 1'b0) begin
      failures++;
      $display("FAIL ready_int_clears actual=%b required=0", ap_loop_init);
    end
    ap_start = 1'b0;
    tick;
  endtask

  task automatic test_done;
    ap_loop_exit_done = 1'b1;
    settle;
    checks++;
    if (ap_done !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse actual=%b required=1", ap_done);
    end
    tick;
    ap_loop_exit_done = 1'b0;
    ap_done_int = 1'b1;
    settle;
    checks++;
    if (ap_done !== 1'b0 || ap_continue_int !== 1'b1) begin
      failures++;
      $display("FAIL done_one_cycle actual done=%b cont=%b required 0 1", ap_done, ap_continue_int);
    end
    ap_done_int = 1'b0;
    tick;
  endtask

  task automatic load_vectors;
    va[0] = 29'd95724;        vb[0] = 64'd1000;
    ve[0] = 92'd95724000;
    va[1] = 29'd190532990;    vb[1] = -64'sd2;
    ve[1] = -92'sd381065980;
    va[2] = 29'h1000_0000;    vb[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    ve[2] = -(92'sd1 <<< 91) + (92'sd1 <<< 28);
    va[3] = 29'h1000_0000;    vb[3] = 64'h8000_0000_0000_0000;
    ve[3] = 92'sd1 <<< 91;
    va[4] = 29'h0FFF_FFFF;    vb[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    ve[4] = (92'sd1 <<< 91) - (92'sd1 <<< 63) - (92'sd1 <<< 28) + 92'sd1;
    va[5] = '1;               vb[5] = '1;
    ve[5] = 92'd1;
    va[6] = 29'd0;            vb[6] = 64'd12345;
    ve[6] = 92'd0;
    va[7] = -29'sd7;          vb[7] = 64'd3;
    ve[7] = -92'sd21;
  endtask

  task automatic test_mul_stream(input bit stall);
    logic [91:0] hold;
    mul_ce = 1'b1;
    for (int i = 0; i < NVEC + 3; i++) begin
      if (stall && i == 5) begin
        mul_ce = 1'b0;
        mul_din0 = 29'h155_5555;
        mul_din1 = 64'hDEAD_BEEF_0123_4567;
        hold = mul_dout;
        for (int s = 0; s < 3; s++) begin
          tick;
          checks++;
          if (mul_dout !== hold || mul_dout !== ve[1]) begin
            failures++;
            $display("FAIL ce_freeze cycle=%0d actual=%0h required=%0h", s, mul_dout, ve[1]);
          end
        end
        mul_ce = 1'b1;
      end
      if (i < NVEC) begin
        mul_din0 = va[i];
        mul_din1 = vb[i];
      end else begin
        mul_din0 = 29'd11;
        mul_din1 = 64'd13;
      end
      tick;
      if (i >= 3) begin
        checks++;
        if (mul_dout !== ve[i-3]) begin
          failures++;
          $display("FAIL mul_stream stall=%0d idx=%0d actual=%0h required=%0h",
                   stall, i - 3, mul_dout, ve[i-3]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    ap_start = 1'b1;
    ap_ready_int = 1'b1;
    tick;
    ap_ready_int = 1'b0;
    mul_ce = 1'b1;
    mul_din0 = 29'd100;
    mul_din1 = 64'd100;
    for (int i = 0; i < 4; i++) tick;
    checks++;
    if (mul_dout !== 92'd10000 || ap_loop_init !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset actual dout=%0h init=%b required 2710 0", mul_dout, ap_loop_init);
    end
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (mul_dout !== 92'd0 || ap_loop_init !== 1'b1) begin
      failures++;
      $display("FAIL async_reset actual dout=%0h init=%b required 0 1", mul_dout, ap_loop_init);
    end
    tick;
    ap_rst_n = 1'b1;
    ap_start = 1'b0;
    mul_din0 = 29'd0;
    mul_din1 = 64'd0;
    for (int i = 0; i < 4; i++) tick;
  endtask

  initial begin
    test_reset;
    test_loop_init;
    test_done;
    load_vectors;
    test_mul_stream(1'b0);
    test_mul_stream(1'b1);
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
